// File: rtl/mar_addr_seq.sv
// -----------------------------------------------------------------------------
// mar_addr_seq
//
// Memory-address-register sequencer. Selects the MAR value from one of NIN
// data-input sources or a constant vector table and registers it. It also
// supports single increments and counted bursts, so the memory controller can
// walk sequential addresses without the datapath reloading the MAR each cycle.
//
// Ports:
//   clk          in   1         system clock, rising-edge active
//   reset        in   1         synchronous, active-high reset
//   d_in         in   NIN*AW    flattened sources, source k at [k*AW +: AW]
//   mar_sel      in   SELW      source select (used with mar_ld / burst_start)
//   mar_ld       in   1         load the selected source into mar_q
//   mar_inc      in   1         mar_q += INC (wrapping)
//   burst_start  in   1         load the selected source and start a burst
//   burst_len    in   LENW      burst address count, sampled with burst_start
//   adv          in   1         consumer accepted the current burst address
//   mar_q        out  AW        registered MAR value
//   busy         out  1         high while a burst is in progress
//   done         out  1         one-cycle pulse at burst completion
//   sel_err      out  1         one-cycle pulse on an out-of-range select
// -----------------------------------------------------------------------------
module mar_addr_seq #(
   parameter int          AW    = 32,
   parameter int          NIN   = 3,
   parameter int          SELW  = 4,
   parameter logic [31:0] VEC0  = 32'h3FF,
   parameter logic [31:0] VECB  = 32'h2A1,
   parameter int          VSTEP = 2,
   parameter int          NVEC  = 5,
   parameter int          INC   = 1,
   parameter int          LENW  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NIN*AW-1:0]   d_in,
   input  logic [SELW-1:0]     mar_sel,
   input  logic                mar_ld,
   input  logic                mar_inc,
   input  logic                burst_start,
   input  logic [LENW-1:0]     burst_len,
   input  logic                adv,
   output logic [AW-1:0]       mar_q,
   output logic                busy,
   output logic                done,
   output logic                sel_err
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t            r_state;
   logic [AW-1:0]     r_mar;
   logic [LENW-1:0]   r_rem;
   logic              r_done;
   logic              r_sel_err;

   state_t            w_state_nxt;
   logic [AW-1:0]     w_mar_nxt;
   logic [LENW-1:0]   w_rem_nxt;
   logic              w_done_nxt;
   logic              w_sel_err_nxt;

   logic [AW-1:0]     w_src;
   logic              w_sel_ok;
   logic [AW-1:0]     w_mar_plus;

   // Source decode: data inputs first, then the fixed vector, then the table.
   // Vector constants are resized to AW bits (truncate or zero-extend).
   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_src    = '0;
      w_sel_ok = 1'b0;
      for (int k = 0; k < NIN; k++) begin
         if (mar_sel == SELW'(k)) begin
            w_src    = d_in[k*AW +: AW];
            w_sel_ok = 1'b1;
         end
      end
      if (mar_sel == SELW'(NIN)) begin
         w_src    = AW'(VEC0);
         w_sel_ok = 1'b1;
      end
      for (int k = 0; k < NVEC; k++) begin
         if (mar_sel == SELW'(NIN + 1 + k)) begin
            w_src    = AW'(VECB + 32'(k * VSTEP));
            w_sel_ok = 1'b1;
         end
      end
   end

   // Increment wraps modulo 2^AW by construction of the AW-bit add.
   assign w_mar_plus = r_mar + AW'(INC);

   // Next-state and command handling.
   always_comb begin
      w_state_nxt   = r_state;
      w_mar_nxt     = r_mar;
      w_rem_nxt     = r_rem;
      w_done_nxt    = 1'b0;
      w_sel_err_nxt = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            // Priority: burst_start > mar_ld > mar_inc > hold.
            if (burst_start) begin
               if (w_sel_ok) begin
                  w_mar_nxt = w_src;
                  if (burst_len != '0) begin
                     w_rem_nxt   = burst_len;
                     w_state_nxt = S_BURST;
                  end else begin
                     // Zero-length burst completes immediately.
                     w_done_nxt = 1'b1;
                  end
               end else begin
                  w_sel_err_nxt = 1'b1;
               end
            end else if (mar_ld) begin
               if (w_sel_ok) begin
                  w_mar_nxt = w_src;
               end else begin
                  w_sel_err_nxt = 1'b1;
               end
            end else if (mar_inc) begin
               w_mar_nxt = w_mar_plus;
            end
         end

         S_BURST: begin
            // Load/inc/start/select are ignored here; only adv matters.
            if (adv) begin
               w_mar_nxt = w_mar_plus;
               w_rem_nxt = r_rem - LENW'(1);
               if (r_rem == LENW'(1)) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_mar     <= '0;
         r_rem     <= '0;
         r_done    <= 1'b0;
         r_sel_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mar     <= w_mar_nxt;
         r_rem     <= w_rem_nxt;
         r_done    <= w_done_nxt;
         r_sel_err <= w_sel_err_nxt;
      end
   end

   assign mar_q   = r_mar;
   assign busy    = (r_state == S_BURST);
   assign done    = r_done;
   assign sel_err = r_sel_err;

endmodule
